// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PC and IR, runs a variable-latency handshake with
// instruction memory, and handles stall and branch/jump redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [24:0] inm_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] target_aligned;

  assign target_aligned = {pc_target_i[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    redirect_d    = redirect_q;
    misaligned_d  = misaligned_q | (pc_load_i & (pc_target_i[1:0] != 2'b00));

    unique case (state_q)
      StFetch: begin
        if (imem_ack_i) begin
          if (pc_load_i) begin
            pc_d = target_aligned;
          end else begin
            instr_d       = imem_rdata_i;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end else if (pc_load_i) begin
          // Keep pc (and hence imem_addr) stable until the abandoned fetch completes.
          redirect_d = target_aligned;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (pc_load_i) redirect_d = target_aligned;
        if (imem_ack_i) begin
          pc_d    = pc_load_i ? target_aligned : redirect_q;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (pc_load_i) begin
          pc_d          = target_aligned;
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
          state_d       = StFetch;
        end else if (!stall_i) begin
          pc_d          = pc_q + 32'd4;
          instr_valid_d = 1'b0;
          state_d       = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      redirect_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      redirect_q    <= redirect_d;
    end
  end

  // Request drops during reset so memory abandons any outstanding transaction.
  assign imem_req_o    = !reset_i && (state_q == StFetch || state_q == StDrain);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign inm_o         = instr_q[31:7];
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic checked against
// a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, pc_load, imem_ack;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [24:0] inm;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  if_stage dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .pc_load_i    (pc_load),
    .pc_target_i  (pc_target),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .inm_o        (inm),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .misaligned_o (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic set_in(input logic r, input logic s, input logic l, input logic [31:0] t,
                        input logic a, input logic [31:0] d);
    reset = r; stall = s; pc_load = l; pc_target = t; imem_ack = a; imem_rdata = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req);
    else pass_cnt++;
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else pass_cnt++;
    chk_cnt++; if (instr !== Nop) $display("FAIL rst_instr got %h want %h", instr, Nop);
    else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0 || misaligned !== 1'b0)
      $display("FAIL rst_flags got v=%b m=%b want 0 0", instr_valid, misaligned);
    else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL rst_first_req got req=%b addr=%h want 1 0", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    set_in(0, 0, 0, 0, 1, 32'h9CF0_0013);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (instr_valid !== 1'b1 || instr !== 32'h9CF0_0013)
      $display("FAIL zw_instr got v=%b %h want 1 9cf00013", instr_valid, instr);
    else pass_cnt++;
    chk_cnt++; if (inm !== 25'h139E000) $display("FAIL zw_inm got %h want 139e000", inm);
    else pass_cnt++;
    chk_cnt++; if (pc !== 32'h0 || imem_req !== 1'b0)
      $display("FAIL zw_pc got pc=%h req=%b want 0 0", pc, imem_req);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    set_in(0, 0, 1, 32'h100, 0, 0);  // HOLD -> FETCH @0x100
    step();
    set_in(0, 0, 0, 0, 1, 32'h1234_5678);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
      step();
      chk_cnt++;
      if (pc !== 32'h100 || instr !== 32'h1234_5678 || instr_valid !== 1'b1)
        $display("FAIL stall_hold%0d got pc=%h i=%h v=%b want 100 12345678 1",
                 i, pc, instr, instr_valid);
      else pass_cnt++;
    end
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk_cnt++; if (pc !== 32'h104 || imem_req !== 1'b1 || instr_valid !== 1'b0)
      $display("FAIL stall_release got pc=%h req=%b v=%b want 104 1 0", pc, imem_req, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    bit seen_valid = 0;
    set_in(0, 0, 1, 32'h200, 1, 0);  // ack+redirect: refetch at 0x200
    step();
    set_in(0, 0, 1, 32'h400, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, (i == 3), 32'hBAD0_0BAD);
      #1;
      chk_cnt++; if (imem_addr !== 32'h200 || imem_req !== 1'b1)
        $display("FAIL drain_addr%0d got req=%b addr=%h want 1 200", i, imem_req, imem_addr);
      else pass_cnt++;
      if (instr_valid) seen_valid = 1;
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (imem_addr !== 32'h400 || imem_req !== 1'b1 || instr_valid !== 1'b0 || seen_valid)
      $display("FAIL drain_next got addr=%h req=%b v=%b seen=%b want 400 1 0 0",
               imem_addr, imem_req, instr_valid, seen_valid);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    set_in(0, 0, 0, 0, 1, 32'h7777_7777);
    step();
    set_in(0, 1, 1, 32'h0000_0803, 0, 0);
    step();
    chk_cnt++; if (pc !== 32'h800 || misaligned !== 1'b1)
      $display("FAIL mis_redirect got pc=%h m=%b want 800 1", pc, misaligned);
    else pass_cnt++;
    chk_cnt++; if (instr !== Nop || instr_valid !== 1'b0)
      $display("FAIL mis_flush got i=%h v=%b want 00000013 0", instr, instr_valid);
    else pass_cnt++;
    set_in(0, 0, 1, 32'h900, 1, 0);
    step();
    chk_cnt++; if (pc !== 32'h900 || misaligned !== 1'b1)
      $display("FAIL mis_sticky got pc=%h m=%b want 900 1", pc, misaligned);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    set_in(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    step();
    set_in(0, 0, 0, 0, 1, 32'h0010_0093);
    step();
    chk_cnt++; if (pc_plus4 !== 32'h0 || instr_valid !== 1'b1)
      $display("FAIL wrap_plus4 got %h v=%b want 0 1", pc_plus4, instr_valid);
    else pass_cnt++;
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk_cnt++; if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1)
      $display("FAIL wrap_fetch got pc=%h addr=%h req=%b want 0 0 1", pc, imem_addr, imem_req);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 1, 32'h40, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rmid_req got %b want 0", imem_req);
    else pass_cnt++;
    step();
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rmid_req2 got %b want 0", imem_req);
    else pass_cnt++;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt++;
    if (pc !== 32'h0 || instr !== Nop || instr_valid !== 1'b0 || misaligned !== 1'b0)
      $display("FAIL rmid_state got pc=%h i=%h v=%b m=%b want 0 00000013 0 0",
               pc, instr, instr_valid, misaligned);
    else pass_cnt++;
  endtask

  // Model: one outstanding request at m_addr (m_busy), an optional queued redirect
  // that applies once the abandoned fetch completes, and the presented instruction.
  task automatic test_random(input int cycles);
    bit          m_busy = 1, m_valid = 0, m_mis = 0, m_redir_v = 0;
    logic [31:0] m_addr = 32'h0, m_instr = Nop, m_redir = 32'h0, t;
    logic        r, s, l, a;
    logic [31:0] tg;
    for (int c = 0; c < cycles; c++) begin
      r  = ($urandom_range(99) == 0);
      s  = ($urandom_range(1) == 0);
      l  = ($urandom_range(9) == 0);
      a  = ($urandom_range(2) == 0);
      tg = {$urandom_range(255), 2'b00};
      if ($urandom_range(3) == 0) tg[1:0] = 2'($urandom_range(3));
      set_in(r, s, l, tg, a, mem_word(imem_addr));
      #1;
      chk_cnt++; if (imem_req !== (m_busy && !r))
        $display("FAIL rnd_req c=%0d got %b want %b", c, imem_req, m_busy && !r);
      else pass_cnt++;
      chk_cnt++; if (imem_addr !== m_addr || pc !== m_addr || pc_plus4 !== m_addr + 32'd4)
        $display("FAIL rnd_pc c=%0d got %h/%h want %h", c, pc, pc_plus4, m_addr);
      else pass_cnt++;
      chk_cnt++; if (instr_valid !== m_valid || instr !== m_instr || inm !== m_instr[31:7])
        $display("FAIL rnd_instr c=%0d got v=%b %h want v=%b %h", c, instr_valid, instr,
                 m_valid, m_instr);
      else pass_cnt++;
      chk_cnt++; if (misaligned !== m_mis)
        $display("FAIL rnd_mis c=%0d got %b want %b", c, misaligned, m_mis);
      else pass_cnt++;
      step();
      t = {tg[31:2], 2'b00};
      if (r) begin
        m_busy = 1; m_valid = 0; m_mis = 0; m_redir_v = 0; m_addr = 32'h0; m_instr = Nop;
      end else begin
        if (l && tg[1:0] != 2'b00) m_mis = 1;
        if (m_busy) begin
          if (a) begin
            if (l) m_addr = t;
            else if (m_redir_v) m_addr = m_redir;
            else begin m_valid = 1; m_instr = mem_word(m_addr); m_busy = 0; end
            m_redir_v = 0;
          end else if (l) begin
            m_redir_v = 1; m_redir = t;
          end
        end else if (l) begin
          m_addr = t; m_valid = 0; m_instr = Nop; m_busy = 1;
        end else if (!s) begin
          m_addr = m_addr + 32'd4; m_valid = 0; m_busy = 1;
        end
      end
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0);
    step();
    test_reset();
    test_zero_wait();
    test_stall();
    test_drain();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random(3000);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
